// File: rtl/program_memory.sv
// program_memory: run-time loadable instruction RAM for the nibble CPU with a registered fetch port.
// Optional per-word even parity when PROGRAM_MEMORY_PARITY_EN is defined.
module program_memory #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count,
  output logic              cpu_run,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data
`ifdef PROGRAM_MEMORY_PARITY_EN
  ,
  output logic              fetch_parity_err
`endif
);

`ifdef PROGRAM_MEMORY_PARITY_EN
  localparam int unsigned MemW = DATA_W + 1;
`else
  localparam int unsigned MemW = DATA_W;
`endif
  localparam logic [ADDR_W:0] DepthL  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LastIdx = DepthL - 1'b1;

  typedef enum logic [1:0] {StEmpty, StLoad, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DEPTH-1:0]  written_q, written_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [MemW-1:0]   wr_word;
  logic [MemW-1:0]   rd_word;
  logic              fetch_hit;
  logic              in_range;
  logic              rd_ok;

  logic [MemW-1:0] mem [DEPTH];

  // The load counter doubles as the write pointer; it only reaches DEPTH once in RUN.
  assign wr_addr    = count_q[ADDR_W-1:0];
  assign load_ready = (state_q == StLoad);
  assign cpu_run    = (state_q == StRun);
  assign load_count = count_q;

`ifdef PROGRAM_MEMORY_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  if (DEPTH < (1 << ADDR_W)) begin : g_range
    assign in_range = ({1'b0, fetch_addr} < DepthL);
  end else begin : g_full
    assign in_range = 1'b1;
  end

  assign rd_word = mem[fetch_addr];
  assign rd_ok   = in_range && written_q[fetch_addr];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    written_d = written_q;
    wr_en     = 1'b0;
    fetch_hit = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (load_start) begin
          state_d   = StLoad;
          count_d   = '0;
          written_d = '0;
        end
      end
      StLoad: begin
        if (load_start) begin
          count_d   = '0;
          written_d = '0;
        end else if (load_valid) begin
          wr_en              = 1'b1;
          written_d[wr_addr] = 1'b1;
          count_d            = count_q + 1'b1;
          if (load_last || (count_q == LastIdx)) state_d = StRun;
        end
      end
      StRun: begin
        if (load_start) begin
          state_d   = StLoad;
          count_d   = '0;
          written_d = '0;
        end else begin
          fetch_hit = fetch_en;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      count_q     <= '0;
      written_q   <= '0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      written_q   <= written_d;
      fetch_valid <= fetch_hit;
      if (fetch_hit) fetch_data <= rd_ok ? rd_word[DATA_W-1:0] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

`ifdef PROGRAM_MEMORY_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_parity_err <= 1'b0;
    else        fetch_parity_err <= fetch_hit && rd_ok && (^rd_word);
  end
`endif

endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: queue-based program model checked every cycle, plus literal checks.
module tb_program_memory;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_start, load_valid, load_last, fetch_en;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] fetch_addr;
  logic              load_ready, cpu_run, fetch_valid;
  logic [ADDR_W:0]   load_count;
  logic [DATA_W-1:0] fetch_data;
  logic              perr;

  program_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .load_count  (load_count),
    .cpu_run     (cpu_run),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
`ifdef PROGRAM_MEMORY_PARITY_EN
    .fetch_data  (fetch_data),
    .fetch_parity_err (perr)
`else
    .fetch_data  (fetch_data)
`endif
  );
`ifndef PROGRAM_MEMORY_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: the program is simply the list of words accepted since the last load_start.
  bit               m_loading, m_running, m_flip0;
  logic [DATA_W-1:0] m_prog[$];
  logic              m_fv, m_perr;
  logic [DATA_W-1:0] m_fd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0; m_running = 0; m_flip0 = 0;
    m_prog.delete();
    m_fv = 0; m_fd = '0; m_perr = 0;
  endtask

  task automatic model_update();
    m_fv = 0; m_perr = 0;
    if (m_running && fetch_en && !load_start) begin
      m_fv   = 1;
      m_fd   = (int'(fetch_addr) < m_prog.size()) ? m_prog[fetch_addr] : '0;
      m_perr = m_flip0 && (fetch_addr == 0) && (m_prog.size() > 0);
    end
    if (load_start) begin
      m_loading = 1; m_running = 0; m_flip0 = 0;
      m_prog.delete();
    end else if (m_loading && load_valid) begin
      m_prog.push_back(load_data);
      if (load_last || m_prog.size() == DEPTH) begin
        m_loading = 0; m_running = 1;
      end
    end
  endtask

  task automatic idle();
    load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    fetch_en = 0; fetch_addr = '0;
  endtask

  // Inputs are held across the edge; the model consumes them just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
    model_update();
    idle();
  endtask

  task automatic start_load();
    load_start = 1;
    cyc();
  endtask

  task automatic put(input logic [DATA_W-1:0] d, input logic last);
    load_valid = 1; load_data = d; load_last = last;
    cyc();
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string nm);
    fetch_en = 1; fetch_addr = a;
    cyc();
    check({nm, "_valid"}, 32'(fetch_valid), 32'd1);
    check({nm, "_data"}, 32'(fetch_data), 32'(exp));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("load_ready", 32'(load_ready), 32'(m_loading));
      check("cpu_run", 32'(cpu_run), 32'(m_running));
      check("load_count", 32'(load_count), 32'(m_prog.size()));
      check("fetch_valid", 32'(fetch_valid), 32'(m_fv));
      check("fetch_data", 32'(fetch_data), 32'(m_fd));
      check("fetch_parity_err", 32'(perr), 32'(m_perr));
    end
  end

  initial begin
    logic [DATA_W-1:0] exp4 [4];
    exp4 = '{8'h35, 8'h00, 8'h34, 8'h00};
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Fetch while empty is dropped
    fetch_en = 1; fetch_addr = '0;
    cyc();
    fetch_en = 1;
    cyc();
    check("empty_fetch_valid", 32'(fetch_valid), 32'd0);
    check("empty_cpu_run", 32'(cpu_run), 32'd0);
    check("empty_load_ready", 32'(load_ready), 32'd0);

    // Short program with load_last
    start_load();
    check("load_ready_after_start", 32'(load_ready), 32'd1);
    put(8'h35, 0);
    put(8'h00, 0);
    put(8'h34, 1);
    check("short_count", 32'(load_count), 32'd3);
    check("short_run", 32'(cpu_run), 32'd1);
    for (int i = 0; i < 4; i++) fetch(ADDR_W'(i), exp4[i], "short_fetch");

    // Full-depth load with no load_last; word 33 must be refused
    start_load();
    for (int i = 0; i < 33; i++) put(8'(i * 7 + 3), 0);
    check("full_count", 32'(load_count), 32'd32);
    check("full_run", 32'(cpu_run), 32'd1);
    check("full_ready", 32'(load_ready), 32'd0);
    fetch(5'd31, 8'hDC, "full_last");
    fetch(5'd0, 8'h03, "full_first");

    // Reload hides the old program
    start_load();
    for (int i = 0; i < 5; i++) put(8'(8'h50 + i), i == 4);
    fetch(5'd3, 8'h53, "five_w3");
    load_start = 1; fetch_en = 1; fetch_addr = 5'd2;
    cyc();
    check("start_drops_fetch", 32'(fetch_valid), 32'd0);
    put(8'hAA, 0);
    put(8'hBB, 1);
    fetch(5'd2, 8'h00, "stale_w2");
    fetch(5'd1, 8'hBB, "reload_w1");

    // Restart mid-stream; data on the restart cycle is ignored
    start_load();
    put(8'h01, 0); put(8'h02, 0); put(8'h03, 0);
    load_start = 1; load_valid = 1; load_data = 8'hEE;
    cyc();
    put(8'h11, 1);
    check("restart_count", 32'(load_count), 32'd1);
    fetch(5'd0, 8'h11, "restart_w0");
    fetch(5'd1, 8'h00, "restart_w1");

    // Reset during a load
    start_load();
    put(8'h77, 0); put(8'h78, 0);
    rst_n = 0;
    model_reset();
    #2;
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);
    #1 rst_n = 1;
    fetch_en = 1; fetch_addr = '0;
    cyc();
    check("rst_fetch_dropped", 32'(fetch_valid), 32'd0);

`ifdef PROGRAM_MEMORY_PARITY_EN
    start_load();
    put(8'h35, 0);
    put(8'h34, 1);
    dut.mem[0][DATA_W] = ~dut.mem[0][DATA_W];
    m_flip0 = 1;
    fetch(5'd0, 8'h35, "par_bad");
    check("par_err_set", 32'(perr), 32'd1);
    fetch(5'd1, 8'h34, "par_good");
    check("par_err_clear", 32'(perr), 32'd0);
`endif

    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
